inst_cache_dm: RTL and testbench

Parametrised, direct-mapped instruction cache with line refill from a word-wide backing memory. It is the successor to the fixed `inst_cache`:
- line count and line width are configurable;
- misses are serviced by a refill state machine over a valid/ready memory handshake;
- a request handshake and a whole-cache flush are provided.

It sits between the fetch stage (word address in, instruction word out) and instruction memory.

---
 rtl/inst_cache_dm_pkg.sv | 13 +
 rtl/inst_cache_refill_ctrl.sv | 73 +++++++
 rtl/inst_cache_dm.sv | 123 ++++++++++++
 tb/tb_inst_cache_dm.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default word
// width and the refill controller state encoding.
package inst_cache_dm_pkg;

  localparam int DEFAULT_WORD_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/inst_cache_refill_ctrl.sv
// Refill controller: owns the IDLE/REFILL/RESP sequence, the word counter and
// the word-wide memory handshake, and tells the arrays which word to write.
module inst_cache_refill_ctrl
  import inst_cache_dm_pkg::*;
#(
  parameter int WORD_SIZE      = DEFAULT_WORD_SIZE,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [WORD_SIZE-$clog2(WORDS_PER_LINE)-1:0] line_addr,
  input  logic                                  mem_valid,
  output logic                                  mem_req,
  output logic [WORD_SIZE-1:0]                  mem_addr,
  output logic                                  line_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0]     line_word,
  output logic                                  line_done,
  output logic [1:0]                            state
);

  localparam int OFF = $clog2(WORDS_PER_LINE);

  state_t                 state_q;
  state_t                 state_d;
  logic [OFF-1:0]         cnt_q;
  logic [WORD_SIZE-OFF-1:0] base_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start && state_q == ST_IDLE) begin
        base_q <= line_addr;
        cnt_q  <= '0;
      end else if (line_we) begin
        // Wraps modulo WORDS_PER_LINE, so it is back at 0 for the next refill.
        cnt_q <= cnt_q + OFF'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        mem_req = 1'b1;
        if (line_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The line base has zero offset bits, so concatenation is the base+counter sum.
  assign mem_addr  = {base_q, cnt_q};
  assign line_we   = mem_req & mem_valid;
  assign line_done = line_we & (cnt_q == OFF'(WORDS_PER_LINE - 1));
  assign line_word = cnt_q;
  assign state     = state_q;

endmodule

// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache: tag/valid/data arrays and hit compare at
// this level, line refill sequencing in inst_cache_refill_ctrl.
module inst_cache_dm
  import inst_cache_dm_pkg::*;
#(
  parameter int WORD_SIZE      = DEFAULT_WORD_SIZE,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [WORD_SIZE-1:0] req_addr,
  output logic                 req_ready,
  input  logic                 flush,
  output logic [WORD_SIZE-1:0] out,
  output logic                 out_valid,
  output logic                 hit,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_valid,
  input  logic [WORD_SIZE-1:0] mem_data
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = WORD_SIZE - OFF - IDX;

  // Handshakes: a request transfers on a rising edge where req_valid and
  // req_ready are both high; a refill word transfers on an edge where mem_req
  // and mem_valid are both high (mem_addr holds until then); out_valid is a
  // one-cycle pulse with no back-pressure.

  logic [OFF-1:0]       req_off;
  logic [IDX-1:0]       req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [WORD_SIZE-1:0] miss_addr_q;
  logic [OFF-1:0]       miss_off;
  logic [IDX-1:0]       miss_idx;
  logic [TAG_W-1:0]     miss_tag;

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [WORD_SIZE-1:0] data_mem [LINES][WORDS_PER_LINE];

  logic [1:0]           ctrl_state;
  logic                 ctrl_idle;
  logic                 ctrl_resp;
  logic                 accept;
  logic                 lookup_hit;
  logic                 miss_start;
  logic                 line_we;
  logic                 line_done;
  logic [OFF-1:0]       line_word;

  assign req_off  = req_addr[OFF-1:0];
  assign req_idx  = req_addr[OFF+IDX-1:OFF];
  assign req_tag  = req_addr[WORD_SIZE-1:OFF+IDX];
  assign miss_off = miss_addr_q[OFF-1:0];
  assign miss_idx = miss_addr_q[OFF+IDX-1:OFF];
  assign miss_tag = miss_addr_q[WORD_SIZE-1:OFF+IDX];

  assign ctrl_idle  = (ctrl_state == ST_IDLE);
  assign ctrl_resp  = (ctrl_state == ST_RESP);
  assign req_ready  = ctrl_idle & ~flush;
  assign accept     = req_valid & req_ready;
  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign miss_start = accept & ~lookup_hit;

  inst_cache_refill_ctrl #(
    .WORD_SIZE      (WORD_SIZE),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (miss_start),
    .line_addr (req_addr[WORD_SIZE-1:OFF]),
    .mem_valid (mem_valid),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .line_we   (line_we),
    .line_word (line_word),
    .line_done (line_done),
    .state     (ctrl_state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      miss_addr_q <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      hit         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      hit       <= 1'b0;
      // The line being refilled stays invalid until its last word lands.
      if (ctrl_idle && flush) begin
        valid_q <= '0;
      end else if (miss_start) begin
        valid_q[req_idx] <= 1'b0;
      end else if (line_done) begin
        valid_q[miss_idx] <= 1'b1;
      end
      if (miss_start) miss_addr_q <= req_addr;
      if (accept && lookup_hit) begin
        out       <= data_mem[req_idx][req_off];
        out_valid <= 1'b1;
        hit       <= 1'b1;
      end else if (ctrl_resp) begin
        out       <= data_mem[miss_idx][miss_off];
        out_valid <= 1'b1;
      end
    end
  end

  // Tags and data carry no reset; validity alone decides whether they count.
  always_ff @(posedge clk) begin
    if (rst_n && line_we) data_mem[miss_idx][line_word] <= mem_data;
    if (rst_n && line_done) tag_mem[miss_idx] <= miss_tag;
  end

endmodule

// File: tb/tb_inst_cache_dm.sv
// Bench for inst_cache_dm (LINES=4, WORDS_PER_LINE=4): directed scenarios plus
// random fetch traffic, scored against an abstract cache model.
module tb_inst_cache_dm;

  localparam int LINES = 4;
  localparam int WPL   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        req_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;

  inst_cache_dm #(
    .WORD_SIZE      (32),
    .LINES          (LINES),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .out       (out),
    .out_valid (out_valid),
    .hit       (hit),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q[$];
  int          resp_cyc_q[$];
  logic [31:0] addr_log[$];

  bit          m_valid[LINES];
  logic [31:0] m_tag[LINES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Abstract model: a line is a (valid, tag) pair; memory content is a+0x100.
  function automatic void model_req(input logic [31:0] a);
    int          idx;
    logic [31:0] tag;
    bit          h;
    idx = int'((a / WPL) % LINES);
    tag = a / (WPL * LINES);
    h = m_valid[idx] && (m_tag[idx] == tag);
    if (!h) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    exp_q.push_back({h, a + 32'h100});
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // ---------------- memory responder ----------------
  int          mem_wait = 0;
  bit          mem_wait_rand = 1'b0;
  int          cur_wait = 0;
  int          wait_cnt = 0;
  int          stray_cycles = 0;
  int          hold_err = 0;
  logic [31:0] held_addr = '0;

  always @(negedge clk) begin
    if (stray_cycles > 0) begin
      mem_valid = 1'b1;
      mem_data  = 32'hdead_beef;
      stray_cycles--;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt == 0) begin
        held_addr = mem_addr;
        cur_wait  = mem_wait_rand ? int'($urandom_range(0, 2)) : mem_wait;
      end else if (mem_addr != held_addr) begin
        hold_err++;
      end
      if (wait_cnt >= cur_wait) begin
        mem_valid = 1'b1;
        mem_data  = mem_addr + 32'h100;
        addr_log.push_back(mem_addr);
        wait_cnt = 0;
      end else begin
        mem_valid = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_valid = 1'b0;
      wait_cnt  = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (rst_n && out_valid) begin
      resp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got out=%0h hit=%0b, expected no response", out, hit);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", {32'h0, out}, {32'h0, e[31:0]});
        chk("resp_hit", {63'h0, hit}, {63'h0, e[32]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, output int acc);
    bit done;
    done = 1'b0;
    acc  = 0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (req_ready) begin
        model_req(a);
        acc  = cyc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: addr %0h never accepted, required acceptance", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_refill(input string name, input logic [31:0] base, input int acc, input int lat);
    chk({name, "_words"}, addr_log.size(), WPL);
    for (int i = 0; i < WPL; i++)
      chk({name, "_mem_addr"}, (addr_log.size() > i) ? addr_log[i] : 32'hffff_ffff, base + i);
    chk({name, "_latency"}, (resp_cyc_q.size() > 0) ? resp_cyc_q[0] - acc : -1, lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2;
    logic [31:0] ra;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // cold miss
    addr_log.delete(); resp_cyc_q.delete();
    issue(32'd1, a1); drain();
    check_refill("cold", 32'd0, a1, 6);

    // back-to-back hits
    resp_cyc_q.delete();
    issue(32'd2, a1); issue(32'd3, a2); drain();
    chk("hit_b2b_accept", a2 - a1, 1);
    chk("hit0_latency", (resp_cyc_q.size() > 0) ? resp_cyc_q[0] - a1 : -1, 1);
    chk("hit1_latency", (resp_cyc_q.size() > 1) ? resp_cyc_q[1] - a2 : -1, 1);

    // conflict in index 0
    addr_log.delete(); resp_cyc_q.delete();
    issue(32'd17, a1); drain();
    check_refill("conflict", 32'd16, a1, 6);
    addr_log.delete(); resp_cyc_q.delete();
    issue(32'd1, a1); drain();
    check_refill("reload", 32'd0, a1, 6);

    // flush beats a simultaneous request
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'd2;
    #1 chk("flush_req_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    model_clear();
    addr_log.delete(); resp_cyc_q.delete();
    issue(32'd2, a1); drain();
    check_refill("after_flush", 32'd0, a1, 6);

    // two wait states per word
    mem_wait = 2; hold_err = 0;
    addr_log.delete(); resp_cyc_q.delete();
    issue(32'd40, a1); drain();
    check_refill("wait", 32'd40, a1, 14);
    chk("wait_addr_hold", hold_err, 0);

    // reset in the middle of a refill
    mem_wait = 3;
    addr_log.delete();
    issue(32'd21, a1);
    for (int i = 0; i < 100 && addr_log.size() < 2; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    model_clear();
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    rst_n = 1'b1; mem_wait = 0; stray_cycles = 2;
    repeat (3) @(negedge clk);
    chk("stray_mem_req", mem_req, 0);
    addr_log.delete(); resp_cyc_q.delete();
    issue(32'd1, a1); drain();
    check_refill("post_rst", 32'd0, a1, 6);

    // random traffic with random wait states and occasional flushes
    mem_wait_rand = 1'b1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        drain();
        flush = 1'b1;
        req_valid = 1'($urandom_range(0, 1));
        req_addr = $urandom;
        #1 chk("rand_flush_req_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        model_clear();
      end else begin
        if ($urandom_range(0, 3) == 3) ra = 32'hffff_ffc0 + $urandom_range(0, 63);
        else ra = $urandom_range(0, 63);
        issue(ra, a1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();
    mem_wait_rand = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
